// File: rtl/alu_issue_stage.sv
// rtl/alu_issue_stage.sv - ID/EX issue stage: operand forwarding, load-use blocking, registered ALU inputs
module alu_issue_stage #(
    parameter int XLEN   = 32,
    parameter int REGW   = 5,
    parameter int STALLW = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [REGW-1:0]   in_rs1,
    input  logic [REGW-1:0]   in_rs2,
    input  logic [XLEN-1:0]   in_rs1_data,
    input  logic [XLEN-1:0]   in_rs2_data,
    input  logic [XLEN-1:0]   in_imm,
    input  logic              in_use_imm,
    input  logic [3:0]        in_aluop,
    input  logic [REGW-1:0]   in_rd,
    input  logic              in_reg_write,
    input  logic              fwd1_valid,
    input  logic [REGW-1:0]   fwd1_rd,
    input  logic [XLEN-1:0]   fwd1_data,
    input  logic              fwd1_is_load,
    input  logic              fwd2_valid,
    input  logic [REGW-1:0]   fwd2_rd,
    input  logic [XLEN-1:0]   fwd2_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   alu_a,
    output logic [XLEN-1:0]   alu_b,
    output logic [3:0]        alu_op,
    output logic [REGW-1:0]   out_rd,
    output logic              out_reg_write,
    output logic              out_illegal,
    output logic [STALLW-1:0] stall_cnt
);
    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0110;

    logic              valid_q;
    logic [XLEN-1:0]   a_q, b_q;
    logic [3:0]        op_q;
    logic [REGW-1:0]   rd_q;
    logic              rw_q, ill_q;
    logic [STALLW-1:0] stall_q;

    logic            rs1_m1, rs1_m2, rs2_m1, rs2_m2;
    logic [XLEN-1:0] rs1_val, rs2_val, b_d;
    logic            legal, hazard, capture;

    // EX/MEM wins over MEM/WB because it holds the younger write; x0 never forwards
    assign rs1_m1  = fwd1_valid && (fwd1_rd == in_rs1) && (in_rs1 != '0);
    assign rs1_m2  = fwd2_valid && (fwd2_rd == in_rs1) && (in_rs1 != '0);
    assign rs2_m1  = fwd1_valid && (fwd1_rd == in_rs2) && (in_rs2 != '0);
    assign rs2_m2  = fwd2_valid && (fwd2_rd == in_rs2) && (in_rs2 != '0);
    assign rs1_val = rs1_m1 ? fwd1_data : rs1_m2 ? fwd2_data : in_rs1_data;
    assign rs2_val = rs2_m1 ? fwd1_data : rs2_m2 ? fwd2_data : in_rs2_data;
    assign b_d     = in_use_imm ? in_imm : rs2_val;

    assign legal = (in_aluop == OP_AND) || (in_aluop == OP_OR) ||
                   (in_aluop == OP_ADD) || (in_aluop == OP_SUB);

    // Load data is not available until MEM, so a dependent op must wait a cycle
    assign hazard = in_valid && fwd1_is_load && fwd1_valid && (fwd1_rd != '0) &&
                    ((fwd1_rd == in_rs1) || ((fwd1_rd == in_rs2) && !in_use_imm));

    assign in_ready = rst_n && !hazard && (!valid_q || out_ready);
    assign capture  = in_valid && in_ready && !flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= OP_ADD;
            rd_q    <= '0;
            rw_q    <= 1'b0;
            ill_q   <= 1'b0;
            stall_q <= '0;
        end else begin
            if (flush) begin
                valid_q <= 1'b0;
            end else if (capture) begin
                valid_q <= 1'b1;
                a_q     <= rs1_val;
                b_q     <= b_d;
                op_q    <= legal ? in_aluop : OP_ADD;
                rd_q    <= in_rd;
                rw_q    <= in_reg_write && legal;
                ill_q   <= !legal;
            end else if (out_ready) begin
                valid_q <= 1'b0;
            end
            if (in_valid && !in_ready && (stall_q != '1))
                stall_q <= stall_q + STALLW'(1);
        end
    end

    assign out_valid     = valid_q;
    assign alu_a         = a_q;
    assign alu_b         = b_q;
    assign alu_op        = op_q;
    assign out_rd        = rd_q;
    assign out_reg_write = rw_q;
    assign out_illegal   = ill_q;
    assign stall_cnt     = stall_q;
endmodule

// File: tb/tb_alu_issue_stage.sv
// tb/tb_alu_issue_stage.sv - self-checking bench for alu_issue_stage
module tb_alu_issue_stage;
    logic        clk = 1'b0;
    logic        rst_n, flush, in_valid, in_ready, in_use_imm, in_reg_write;
    logic [4:0]  in_rs1, in_rs2, in_rd, fwd1_rd, fwd2_rd, out_rd;
    logic [31:0] in_rs1_data, in_rs2_data, in_imm, fwd1_data, fwd2_data, alu_a, alu_b;
    logic [3:0]  in_aluop, alu_op;
    logic        fwd1_valid, fwd1_is_load, fwd2_valid;
    logic        out_valid, out_ready, out_reg_write, out_illegal;
    logic [15:0] stall_cnt;

    always #5 clk = ~clk;

    alu_issue_stage dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data),
        .in_imm(in_imm), .in_use_imm(in_use_imm), .in_aluop(in_aluop), .in_rd(in_rd),
        .in_reg_write(in_reg_write), .fwd1_valid(fwd1_valid), .fwd1_rd(fwd1_rd),
        .fwd1_data(fwd1_data), .fwd1_is_load(fwd1_is_load), .fwd2_valid(fwd2_valid),
        .fwd2_rd(fwd2_rd), .fwd2_data(fwd2_data), .out_valid(out_valid), .out_ready(out_ready),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .out_rd(out_rd),
        .out_reg_write(out_reg_write), .out_illegal(out_illegal), .stall_cnt(stall_cnt)
    );

    int n_vec = 0;
    int n_bad = 0;

    // Reference state: what the ALU should currently be seeing
    logic        m_valid, m_rw, m_ill;
    logic [31:0] m_a, m_b;
    logic [3:0]  m_op;
    logic [4:0]  m_rd;
    int          m_stall;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] pick(input logic [4:0] s, input logic [31:0] rf);
        if (s == 0) return rf;
        if (fwd1_valid && fwd1_rd == s) return fwd1_data;
        if (fwd2_valid && fwd2_rd == s) return fwd2_data;
        return rf;
    endfunction

    function automatic bit model_ready();
        bit dep;
        dep = fwd1_valid && fwd1_is_load && fwd1_rd != 0 &&
              (fwd1_rd == in_rs1 || (fwd1_rd == in_rs2 && !in_use_imm));
        return rst_n && !(in_valid && dep) && (!m_valid || out_ready);
    endfunction

    task automatic model_reset();
        m_valid = 0; m_a = 0; m_b = 0; m_op = 4'b0010; m_rd = 0; m_rw = 0; m_ill = 0; m_stall = 0;
    endtask

    task automatic check_outputs();
        check("out_valid", {31'b0, out_valid}, {31'b0, m_valid});
        check("stall_cnt", {16'b0, stall_cnt}, m_stall);
        if (m_valid) begin
            check("alu_a", alu_a, m_a);
            check("alu_b", alu_b, m_b);
            check("alu_op", {28'b0, alu_op}, {28'b0, m_op});
            check("out_rd", {27'b0, out_rd}, {27'b0, m_rd});
            check("out_reg_write", {31'b0, out_reg_write}, {31'b0, m_rw});
            check("out_illegal", {31'b0, out_illegal}, {31'b0, m_ill});
        end
    endtask

    // Inputs are set just after a rising edge; ready is judged at the falling edge
    task automatic tick();
        bit rdy, legal;
        @(negedge clk);
        rdy = model_ready();
        check("in_ready", {31'b0, in_ready}, {31'b0, rdy});
        if (in_valid && !rdy && m_stall < 65535) m_stall++;
        legal = (in_aluop == 4'b0000 || in_aluop == 4'b0001 || in_aluop == 4'b0010 || in_aluop == 4'b0110);
        if (flush) m_valid = 0;
        else if (in_valid && rdy) begin
            m_valid = 1;
            m_a  = pick(in_rs1, in_rs1_data);
            m_b  = in_use_imm ? in_imm : pick(in_rs2, in_rs2_data);
            m_op = legal ? in_aluop : 4'b0010;
            m_rd = in_rd;
            m_rw = in_reg_write && legal;
            m_ill = !legal;
        end else if (out_ready) m_valid = 0;
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    task automatic idle_inputs();
        flush = 0; in_valid = 0; in_rs1 = 0; in_rs2 = 0; in_rs1_data = 0; in_rs2_data = 0;
        in_imm = 0; in_use_imm = 0; in_aluop = 4'b0010; in_rd = 0; in_reg_write = 0;
        fwd1_valid = 0; fwd1_rd = 0; fwd1_data = 0; fwd1_is_load = 0;
        fwd2_valid = 0; fwd2_rd = 0; fwd2_data = 0; out_ready = 1;
    endtask

    task automatic do_reset();
        rst_n = 0;
        model_reset();
        @(posedge clk);
        #1;
        check("rst in_ready", {31'b0, in_ready}, 32'd0);
        check("rst alu_op", {28'b0, alu_op}, 32'd2);
        check("rst alu_a", alu_a, 32'd0);
        check("rst alu_b", alu_b, 32'd0);
        check("rst out_illegal", {31'b0, out_illegal}, 32'd0);
        check_outputs();
        rst_n = 1;
    endtask

    typedef struct {
        logic [4:0]  rs1;  logic [31:0] rs1_data;
        logic        f1v;  logic [4:0]  f1rd; logic [31:0] f1d;
        logic        f2v;  logic [4:0]  f2rd; logic [31:0] f2d;
        logic [4:0]  rs2;  logic [31:0] rs2_data;
        logic        use_imm; logic [31:0] imm;
        logic [3:0]  op;
        logic [31:0] ea, eb; logic [3:0] eop; logic erw, eill;
    } vec_t;

    vec_t vecs[6];
    logic [31:0] held_a, held_b;

    initial begin
        vecs[0] = '{5'd1, 32'h5,  1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 32'h0,  5'd2, 32'h3, 1'b0, 32'h0,        4'b0110, 32'h5,  32'h3,        4'b0110, 1'b1, 1'b0};
        vecs[1] = '{5'd4, 32'h33, 1'b1, 5'd4, 32'h11, 1'b1, 5'd4, 32'h22, 5'd3, 32'h7, 1'b0, 32'h0,        4'b0000, 32'h11, 32'h7,        4'b0000, 1'b1, 1'b0};
        vecs[2] = '{5'd4, 32'h33, 1'b0, 5'd4, 32'h11, 1'b1, 5'd4, 32'h22, 5'd3, 32'h7, 1'b0, 32'h0,        4'b0000, 32'h22, 32'h7,        4'b0000, 1'b1, 1'b0};
        vecs[3] = '{5'd0, 32'h33, 1'b1, 5'd0, 32'h11, 1'b1, 5'd0, 32'h22, 5'd3, 32'h7, 1'b0, 32'h0,        4'b0010, 32'h33, 32'h7,        4'b0010, 1'b1, 1'b0};
        vecs[4] = '{5'd1, 32'h9,  1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 32'h0,  5'd2, 32'h3, 1'b1, 32'hFFFFFFF0, 4'b1111, 32'h9,  32'hFFFFFFF0, 4'b0010, 1'b0, 1'b1};
        vecs[5] = '{5'd7, 32'h1,  1'b1, 5'd7, 32'h66, 1'b1, 5'd6, 32'h55, 5'd6, 32'h2, 1'b0, 32'h0,        4'b0001, 32'h66, 32'h55,       4'b0001, 1'b1, 1'b0};

        idle_inputs();
        #1;
        do_reset();

        for (int i = 0; i < 6; i++) begin
            in_valid = 1; in_rs1 = vecs[i].rs1; in_rs1_data = vecs[i].rs1_data;
            fwd1_valid = vecs[i].f1v; fwd1_rd = vecs[i].f1rd; fwd1_data = vecs[i].f1d;
            fwd2_valid = vecs[i].f2v; fwd2_rd = vecs[i].f2rd; fwd2_data = vecs[i].f2d;
            in_rs2 = vecs[i].rs2; in_rs2_data = vecs[i].rs2_data;
            in_use_imm = vecs[i].use_imm; in_imm = vecs[i].imm; in_aluop = vecs[i].op;
            in_rd = 5'd7; in_reg_write = 1;
            tick();
            check("tbl out_valid", {31'b0, out_valid}, 32'd1);
            check("tbl alu_a", alu_a, vecs[i].ea);
            check("tbl alu_b", alu_b, vecs[i].eb);
            check("tbl alu_op", {28'b0, alu_op}, {28'b0, vecs[i].eop});
            check("tbl out_rd", {27'b0, out_rd}, 32'd7);
            check("tbl out_reg_write", {31'b0, out_reg_write}, {31'b0, vecs[i].erw});
            check("tbl out_illegal", {31'b0, out_illegal}, {31'b0, vecs[i].eill});
        end

        // Load-use stall on rs2, then release
        idle_inputs();
        do_reset();
        in_valid = 1; in_rs1 = 5'd2; in_rs2 = 5'd9; in_aluop = 4'b0010;
        fwd1_valid = 1; fwd1_is_load = 1; fwd1_rd = 5'd9; fwd1_data = 32'hABCD;
        repeat (3) tick();
        check("stall_cnt after 3", {16'b0, stall_cnt}, 32'd3);
        check("stall no capture", {31'b0, out_valid}, 32'd0);
        fwd1_is_load = 0;
        tick();
        check("release capture", {31'b0, out_valid}, 32'd1);
        check("release fwd b", alu_b, 32'hABCD);
        fwd1_is_load = 1; in_use_imm = 1; in_imm = 32'h40;
        tick();
        check("imm no stall", {16'b0, stall_cnt}, 32'd3);
        check("imm b", alu_b, 32'h40);

        // Hold for 4 cycles, then stream 3
        idle_inputs();
        in_valid = 1; in_rs1_data = 32'h100; in_rs2_data = 32'h200; in_aluop = 4'b0001;
        tick();
        held_a = 32'h100; held_b = 32'h200;
        out_ready = 0; in_rs1_data = 32'h999; in_rs2_data = 32'h888;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("hold alu_a", alu_a, held_a);
            check("hold alu_b", alu_b, held_b);
            check("hold in_ready", {31'b0, in_ready}, 32'd0);
        end
        out_ready = 1;
        for (int i = 0; i < 3; i++) begin
            in_rs1_data = 32'h1000 + i;
            tick();
            check("stream valid", {31'b0, out_valid}, 32'd1);
            check("stream a", alu_a, 32'h1000 + i);
        end

        // Flush coincident with handshake
        flush = 1;
        tick();
        check("flush kills", {31'b0, out_valid}, 32'd0);
        flush = 0;

        // Async reset in the middle of a hold
        tick();
        out_ready = 0;
        tick();
        #3;
        rst_n = 0;
        #1;
        check("async rst valid", {31'b0, out_valid}, 32'd0);
        check("async rst op", {28'b0, alu_op}, 32'd2);
        check("async rst ready", {31'b0, in_ready}, 32'd0);
        idle_inputs();
        do_reset();

        // Randomized traffic against the reference
        for (int i = 0; i < 600; i++) begin
            in_valid = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            flush = ($urandom_range(0, 15) == 0);
            in_rs1 = 5'($urandom_range(0, 3)); in_rs2 = 5'($urandom_range(0, 3));
            in_rs1_data = $urandom; in_rs2_data = $urandom; in_imm = $urandom;
            in_use_imm = $urandom_range(0, 1);
            in_aluop = 4'($urandom_range(0, 15)); if ($urandom_range(0, 1) == 1) in_aluop = 4'b0110;
            in_rd = 5'($urandom); in_reg_write = $urandom_range(0, 1);
            fwd1_valid = $urandom_range(0, 1); fwd1_rd = 5'($urandom_range(0, 3));
            fwd1_data = $urandom; fwd1_is_load = ($urandom_range(0, 3) == 0);
            fwd2_valid = $urandom_range(0, 1); fwd2_rd = 5'($urandom_range(0, 3));
            fwd2_data = $urandom;
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
